// File: rtl/alu_mp_seq_pkg.sv
// Shared types for the multi-precision ALU sequencer: request ops, FSM states,
// the core ALU opcode encoding and the fixed operands used on the carry-fix pass.
package definitions;

  typedef enum logic [1:0] {
    MP_ADD  = 2'b00,
    MP_SUB  = 2'b01,
    MP_LSL1 = 2'b10,
    MP_CMP  = 2'b11
  } mp_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDA,
    ST_RDB,
    ST_EXEC,
    ST_FIX,
    ST_WR,
    ST_DONE
  } mp_state_e;

  // Core ALU opcode encoding, shared with the execute stage.
  typedef enum logic [7:0] {
    ALU_ADD = 8'h00,
    ALU_SUB = 8'h01,
    ALU_AND = 8'h02,
    ALU_OR  = 8'h03,
    ALU_XOR = 8'h04,
    ALU_LSL = 8'h05,
    ALU_LSR = 8'h06
  } op_code;

  localparam logic [7:0] FIX_INC     = 8'd1;
  localparam logic [7:0] FIX_OR_MASK = 8'h01;
  localparam logic [7:0] LSL_SHIFT   = 8'd1;

endpackage

// File: rtl/alu_mp_seq_carry.sv
// Derives the byte carry-out (c1) and the carry-fix carry-out (c2) from the
// ALU operands and result; the core ALU's own flags are not used.
module alu_mp_seq_carry
  import definitions::*;
(
  input  mp_op_e     op,
  input  logic [7:0] rs,
  input  logic [7:0] rt,
  input  logic [7:0] result,
  output logic       c1,
  output logic       c2
);

  // On the fix pass rs holds the pre-fix byte, so a SUB borrow is rs == 0.
  always_comb begin
    c1 = 1'b0;
    c2 = 1'b0;
    case (op)
      MP_ADD: begin
        c1 = (result < rs);
        c2 = (result == 8'h00);
      end
      MP_LSL1: begin
        c1 = rs[7];
        c2 = 1'b0;
      end
      default: begin
        c1 = (rs < rt);
        c2 = (rs == 8'h00);
      end
    endcase
  end

endmodule

// File: rtl/alu_mp_seq.sv
// Multi-precision ADD/SUB/LSL1 sequencer driving the 8-bit ALU one byte at a time.
// Define ALU_MP_SEQ_CMP_EN to enable op 11 as CMP (SUB without write-back).
module alu_mp_seq
  import definitions::*;
#(
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [LW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          carry_o,
  output logic          zero_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  output logic [7:0]    alu_rs_o,
  output logic [7:0]    alu_rt_o,
  output logic [8:0]    alu_op_o,
  input  logic [7:0]    alu_result_i
);

  mp_state_e     state, state_nx;
  mp_op_e        op_q;
  logic [AW-1:0] a_base, b_base, d_base;
  logic [LW-1:0] len_q, i_q;
  logic [7:0]    a_q, r_q;
  logic          c_q, c1_q, acc_q, carry_q, zero_q;
  logic          op_ok, wr_inhibit, c1, c2, last_byte;
  logic [AW-1:0] idx;
  op_code        alu_opc;

`ifdef ALU_MP_SEQ_CMP_EN
  assign op_ok      = 1'b1;
  assign wr_inhibit = (op_q == MP_CMP);
`else
  assign op_ok      = (op_i != MP_CMP);
  assign wr_inhibit = 1'b0;
`endif

  assign idx       = AW'(i_q);
  assign last_byte = (i_q == len_q);
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;

  alu_mp_seq_carry u_carry (
    .op     (op_q),
    .rs     (alu_rs_o),
    .rt     (alu_rt_o),
    .result (alu_result_i),
    .c1     (c1),
    .c2     (c2)
  );

  // NOTE: every output and the next state get a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nx    = state;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 8'h00;
    alu_rs_o    = 8'h00;
    alu_rt_o    = 8'h00;
    alu_opc     = ALU_ADD;
    alu_op_o    = '0;
    case (state)
      ST_IDLE: if (start_i && op_ok) state_nx = ST_RDA;
      ST_RDA: begin
        mem_addr_o = a_base + idx;
        state_nx   = (op_q == MP_LSL1) ? ST_EXEC : ST_RDB;
      end
      ST_RDB: begin
        mem_addr_o = b_base + idx;
        state_nx   = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_q == MP_LSL1) begin
          alu_rs_o = mem_rdata_i;
          alu_rt_o = LSL_SHIFT;
          alu_opc  = ALU_LSL;
        end else begin
          alu_rs_o = a_q;
          alu_rt_o = mem_rdata_i;
          if (op_q == MP_ADD) alu_opc = ALU_ADD;
          else                alu_opc = ALU_SUB;
        end
        alu_op_o = {alu_opc, 1'b0};
        state_nx = c_q ? ST_FIX : ST_WR;
      end
      ST_FIX: begin
        alu_rs_o = r_q;
        case (op_q)
          MP_ADD: begin
            alu_rt_o = FIX_INC;
            alu_opc  = ALU_ADD;
          end
          MP_LSL1: begin
            alu_rt_o = FIX_OR_MASK;
            alu_opc  = ALU_OR;
          end
          default: begin
            alu_rt_o = FIX_INC;
            alu_opc  = ALU_SUB;
          end
        endcase
        alu_op_o = {alu_opc, 1'b0};
        state_nx = ST_WR;
      end
      ST_WR: begin
        mem_we_o    = ~wr_inhibit;
        mem_addr_o  = d_base + idx;
        mem_wdata_o = r_q;
        state_nx    = last_byte ? ST_DONE : ST_RDA;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= MP_ADD;
      a_base  <= '0;
      b_base  <= '0;
      d_base  <= '0;
      len_q   <= '0;
      i_q     <= '0;
      a_q     <= 8'h00;
      r_q     <= 8'h00;
      c_q     <= 1'b0;
      c1_q    <= 1'b0;
      acc_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (start_i && op_ok) begin
          op_q   <= mp_op_e'(op_i);
          a_base <= a_addr_i;
          b_base <= b_addr_i;
          d_base <= d_addr_i;
          len_q  <= len_i;
          i_q    <= '0;
          c_q    <= 1'b0;
          acc_q  <= 1'b1;
        end
        ST_RDB: a_q <= mem_rdata_i;
        ST_EXEC: begin
          r_q  <= alu_result_i;
          c1_q <= c1;
          if (!c_q) c_q <= c1;
        end
        ST_FIX: begin
          r_q <= alu_result_i;
          c_q <= c1_q | c2;
        end
        ST_WR: begin
          acc_q <= acc_q & (r_q == 8'h00);
          // Flags are latched on the way into DONE and held until the next run.
          if (last_byte) begin
            carry_q <= c_q;
            zero_q  <= acc_q & (r_q == 8'h00);
          end else begin
            i_q <= i_q + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq with a behavioural byte memory and 8-bit ALU.
module tb_alu_mp_seq;
  import definitions::*;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start_i;
  logic [1:0] op_i;
  logic [7:0] a_addr_i, b_addr_i, d_addr_i;
  logic [3:0] len_i;
  logic       busy_o, done_o, carry_o, zero_o;
  logic [7:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic       mem_we_o;
  logic [7:0] alu_rs_o, alu_rt_o, alu_result_i;
  logic [8:0] alu_op_o;

  int tests = 0;
  int fails = 0;

  alu_mp_seq #(.AW(8), .LW(4)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start_i      (start_i),
    .op_i         (op_i),
    .a_addr_i     (a_addr_i),
    .b_addr_i     (b_addr_i),
    .d_addr_i     (d_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .carry_o      (carry_o),
    .zero_o       (zero_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .alu_rs_o     (alu_rs_o),
    .alu_rt_o     (alu_rt_o),
    .alu_op_o     (alu_op_o),
    .alu_result_i (alu_result_i)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory with one-cycle read latency and a bench load port.
  logic [7:0] mem [0:255];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr, ld_data;
  int         we_count = 0;

  always @(posedge CLK) begin
    mem_rdata_i <= mem[mem_addr_o];
    if (mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
      we_count        <= we_count + 1;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Behavioural ALU.
  logic [7:0] alu_opc;
  assign alu_opc = alu_op_o[8:1];
  always_comb begin
    alu_result_i = 8'h00;
    case (alu_opc)
      ALU_ADD: alu_result_i = alu_rs_o + alu_rt_o;
      ALU_SUB: alu_result_i = alu_rs_o - alu_rt_o;
      ALU_OR:  alu_result_i = alu_rs_o | alu_rt_o;
      ALU_LSL: alu_result_i = alu_rs_o << alu_rt_o;
      default: alu_result_i = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge CLK);
    ld_en   = 1'b0;
  endtask

  // Issues one request from IDLE, optionally pulses start again at cycle
  // poke_cyc, and returns the cycle (after start) at which done_o was seen.
  task automatic run(input string name, input logic [1:0] op,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                     input logic [3:0] len, input int poke_cyc, output int cyc);
    logic hit;
    hit      = 1'b0;
    op_i     = op;
    a_addr_i = a;
    b_addr_i = b;
    d_addr_i = d;
    len_i    = len;
    start_i  = 1'b1;
    @(negedge CLK);
    start_i  = 1'b0;
    cyc      = 1;
    check({name, "_busy_rise"}, 32'(busy_o), 32'd1);
    for (int k = 0; k < 300; k++) begin
      if (done_o) begin
        hit = 1'b1;
        break;
      end
      if (cyc == poke_cyc) begin
        start_i  = 1'b1;
        op_i     = 2'b00;
        a_addr_i = ~a;
        d_addr_i = ~d;
      end else begin
        start_i  = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    start_i = 1'b0;
    check({name, "_done_seen"}, 32'(hit), 32'd1);
    @(negedge CLK);
    check({name, "_done_pulse"}, 32'(done_o), 32'd0);
    check({name, "_busy_fall"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int cyc;
    int we_snap;
    reset    = 1'b1;
    start_i  = 1'b0;
    op_i     = 2'b00;
    a_addr_i = 8'h00;
    b_addr_i = 8'h00;
    d_addr_i = 8'h00;
    len_i    = 4'd0;
    repeat (3) @(negedge CLK);
    check("rst_busy",  32'(busy_o),     32'd0);
    check("rst_done",  32'(done_o),     32'd0);
    check("rst_carry", 32'(carry_o),    32'd0);
    check("rst_zero",  32'(zero_o),     32'd0);
    check("rst_we",    32'(mem_we_o),   32'd0);
    check("rst_aluop", 32'(alu_op_o),   32'd0);
    check("rst_addr",  32'(mem_addr_o), 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // ADD with carry: 0x01FF + 0x0001 = 0x0200.
    poke(8'h10, 8'hFF); poke(8'h11, 8'h01);
    poke(8'h12, 8'h01); poke(8'h13, 8'h00);
    run("add", 2'b00, 8'h10, 8'h12, 8'h14, 4'd1, -1, cyc);
    check("add_cycles", 32'(cyc), 32'd10);
    check("add_d0", 32'(mem[8'h14]), 32'h00);
    check("add_d1", 32'(mem[8'h15]), 32'h02);
    check("add_carry", 32'(carry_o), 32'd0);
    check("add_zero", 32'(zero_o), 32'd0);

    // SUB with borrow, plus an ignored start while busy.
    poke(8'h20, 8'h00); poke(8'h21, 8'h00);
    poke(8'h22, 8'h01); poke(8'h23, 8'h00);
    poke(8'hDB, 8'h77);
    run("sub", 2'b01, 8'h20, 8'h22, 8'h24, 4'd1, 3, cyc);
    check("sub_cycles", 32'(cyc), 32'd10);
    check("sub_d0", 32'(mem[8'h24]), 32'hFF);
    check("sub_d1", 32'(mem[8'h25]), 32'hFF);
    check("sub_carry", 32'(carry_o), 32'd1);
    check("sub_zero", 32'(zero_o), 32'd0);
    check("sub_ignored_start", 32'(mem[8'hDB]), 32'h77);

    // LSL1 across bytes: 0x8080 -> 0x0100 carry 1.
    poke(8'h30, 8'h80); poke(8'h31, 8'h80);
    run("lsl_a", 2'b10, 8'h30, 8'h00, 8'h34, 4'd1, -1, cyc);
    check("lsl_a_cycles", 32'(cyc), 32'd8);
    check("lsl_a_d0", 32'(mem[8'h34]), 32'h00);
    check("lsl_a_d1", 32'(mem[8'h35]), 32'h01);
    check("lsl_a_carry", 32'(carry_o), 32'd1);
    check("lsl_a_zero", 32'(zero_o), 32'd0);

    // LSL1: 0x0180 -> 0x0300 carry 0.
    poke(8'h38, 8'h80); poke(8'h39, 8'h01);
    run("lsl_b", 2'b10, 8'h38, 8'h00, 8'h3C, 4'd1, -1, cyc);
    check("lsl_b_d0", 32'(mem[8'h3C]), 32'h00);
    check("lsl_b_d1", 32'(mem[8'h3D]), 32'h03);
    check("lsl_b_carry", 32'(carry_o), 32'd0);

    // Full-length in-place ADD wrapping through address 0xFF.
    for (int k = 0; k < 16; k++) poke(8'(8'hF8 + k), 8'hFF);
    for (int k = 0; k < 16; k++) poke(8'(8'h40 + k), (k == 0) ? 8'h01 : 8'h00);
    poke(8'h08, 8'hA5);
    poke(8'hF7, 8'h5A);
    run("full", 2'b00, 8'hF8, 8'h40, 8'hF8, 4'd15, -1, cyc);
    check("full_cycles", 32'(cyc), 32'd80);
    for (int k = 0; k < 16; k++)
      check($sformatf("full_d%0d", k), 32'(mem[8'(8'hF8 + k)]), 32'h00);
    check("full_guard_hi", 32'(mem[8'h08]), 32'hA5);
    check("full_guard_lo", 32'(mem[8'hF7]), 32'h5A);
    check("full_carry", 32'(carry_o), 32'd1);
    check("full_zero", 32'(zero_o), 32'd1);

    // Reset in the middle of an ADD.
    for (int k = 0; k < 4; k++) begin
      poke(8'(8'h60 + k), 8'hEE);
      poke(8'(8'h50 + k), 8'h11);
    end
    op_i     = 2'b00;
    a_addr_i = 8'h50;
    b_addr_i = 8'h50;
    d_addr_i = 8'h60;
    len_i    = 4'd3;
    start_i  = 1'b1;
    @(negedge CLK);
    start_i  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mid_busy_before", 32'(busy_o), 32'd1);
    reset   = 1'b1;
    we_snap = we_count;
    @(negedge CLK);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_carry", 32'(carry_o), 32'd0);
    check("rst_mid_zero", 32'(zero_o), 32'd0);
    check("rst_mid_aluop", 32'(alu_op_o), 32'd0);
    check("rst_mid_rs", 32'(alu_rs_o), 32'd0);
    check("rst_mid_we", 32'(mem_we_o), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge CLK);
    check("rst_mid_no_writes", 32'(we_count), 32'(we_snap));
    check("rst_mid_d0", 32'(mem[8'h60]), 32'hEE);
    check("rst_mid_idle", 32'(busy_o), 32'd0);

`ifdef ALU_MP_SEQ_CMP_EN
    // CMP of equal bytes: flags only, no write-back.
    poke(8'h70, 8'h5A); poke(8'h71, 8'h5A); poke(8'h72, 8'h33);
    we_snap = we_count;
    run("cmp", 2'b11, 8'h70, 8'h71, 8'h72, 4'd0, -1, cyc);
    check("cmp_cycles", 32'(cyc), 32'd5);
    check("cmp_zero", 32'(zero_o), 32'd1);
    check("cmp_carry", 32'(carry_o), 32'd0);
    check("cmp_no_we", 32'(we_count), 32'(we_snap));
    check("cmp_d_kept", 32'(mem[8'h72]), 32'h33);
`else
    // Reserved op is ignored.
    op_i     = 2'b11;
    a_addr_i = 8'h70;
    b_addr_i = 8'h71;
    d_addr_i = 8'h72;
    len_i    = 4'd0;
    start_i  = 1'b1;
    @(negedge CLK);
    start_i  = 1'b0;
    check("rsv_busy_1", 32'(busy_o), 32'd0);
    repeat (4) @(negedge CLK);
    check("rsv_busy_5", 32'(busy_o), 32'd0);
    check("rsv_done", 32'(done_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
